// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;
    localparam int unsigned c_entry_w          = 64;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Instruction buffer holding {pc, op} entries, with flush.
// Revision    : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [c_entry_w-1:0]         push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [c_entry_w-1:0]         head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [c_entry_w-1:0] mem_q [DEPTH];
    logic [c_entry_w-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (w_do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Credit-limited instruction fetch with redirect flush handling.
// Revision    : 1.0
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_default_reset_pc,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_op,
    output logic [31:0] dec_pc
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e         state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [CNT_W-1:0]     outstanding_q, outstanding_d;

    logic [CNT_W-1:0]     w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic [c_entry_w-1:0] w_fifo_head;
    logic                 w_credit_ok;
    logic                 w_req_fire;
    logic                 w_rsp_seen;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_rsp_pc;

    assign w_credit_ok = ({1'b0, outstanding_q} + {1'b0, w_fifo_count}) < SUM_W'(FIFO_DEPTH);

    assign imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid && w_credit_ok;
    assign imem_req_addr  = pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses are in order, so the oldest in-flight address sits one word per outstanding request behind the PC.
    assign w_rsp_seen = imem_rsp_valid && (outstanding_q != '0);
    assign w_rsp_pc   = pc_q - (32'(outstanding_q) << 2);
    assign w_push     = w_rsp_seen && (state_q == RUN) && !redirect_valid;

    assign dec_valid = !w_fifo_empty && !redirect_valid;
    assign w_pop     = dec_valid && dec_ready;
    assign dec_op    = w_fifo_head[31:0];
    assign dec_pc    = w_fifo_head[63:32];

    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        outstanding_d = outstanding_q;
        if (w_rsp_seen) begin
            outstanding_d = outstanding_d - CNT_W'(1);
        end
        if (w_req_fire) begin
            outstanding_d = outstanding_d + CNT_W'(1);
            pc_d          = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
        end
        if (redirect_valid || (state_q == FLUSH)) begin
            state_d = (outstanding_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({w_rsp_pc, imem_rsp_data}),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head_data (w_fifo_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomised bench for fetch_unit against a queue-based model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_op;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_op         (dec_op),
        .dec_pc         (dec_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] m_inflight[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_pc;
    bit          m_flushing;
    bit          m_valid;

    int unsigned n_total;
    int unsigned n_bad;
    int unsigned cyc;
    int unsigned p_ready;
    int unsigned p_dec;
    int unsigned p_rsp;

    logic        obs_req_valid;
    logic        obs_acc;
    logic [31:0] obs_req_addr;
    logic        obs_dec_valid;
    logic [31:0] obs_dec_pc;
    logic [31:0] obs_dec_op;

    function automatic logic [31:0] op_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input bit rst_v, input bit redir, input logic [31:0] tgt);
        bit          exp_req;
        bit          exp_dec;
        bit          rsp_now;
        bit          acc_dut;
        logic [31:0] acc_addr;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        rst_n          = rst_v;
        imem_req_ready = ($urandom_range(99) < p_ready);
        dec_ready      = ($urandom_range(99) < p_dec);
        redirect_valid = rst_v && redir;
        redirect_pc    = tgt;
        rsp_now        = rst_v && (mem_q.size() != 0) && (mem_q[0].due <= cyc)
                         && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? op_of(mem_q[0].addr) : $urandom;
        #1;
        exp_req = rst_v && !m_flushing && !redirect_valid
                  && ((m_inflight.size() + m_buf.size()) < DEPTH);
        exp_dec = (m_buf.size() != 0) && !redirect_valid;
        obs_req_valid = imem_req_valid;
        obs_acc       = imem_req_valid && imem_req_ready;
        obs_req_addr  = imem_req_addr;
        obs_dec_valid = dec_valid;
        obs_dec_pc    = dec_pc;
        obs_dec_op    = dec_op;
        if (m_valid) begin
            check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
            check_eq("dec_valid", 32'(dec_valid), 32'(exp_dec));
            if (exp_dec) begin
                check_eq("dec_pc", dec_pc, m_buf[0]);
                check_eq("dec_op", dec_op, op_of(m_buf[0]));
            end
        end
        acc_dut  = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        if (!rst_v) begin
            mem_q.delete();
            m_pc       = RST_PC;
            m_flushing = 1'b0;
            m_inflight.delete();
            m_buf.delete();
            m_valid    = 1'b1;
        end else begin
            if (rsp_now) void'(mem_q.pop_front());
            if (acc_dut) mem_q.push_back('{addr: acc_addr, due: cyc + 1});
            if (exp_dec && dec_ready) void'(m_buf.pop_front());
            if (rsp_now && (m_inflight.size() != 0)) begin
                a = m_inflight.pop_front();
                if (!m_flushing && !redirect_valid) m_buf.push_back(a);
            end
            if (exp_req && imem_req_ready) begin
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_buf.delete();
                m_pc = {tgt[31:2], 2'b00};
            end
            m_flushing = (m_flushing || redirect_valid) && (m_inflight.size() != 0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] first_addr;
        int unsigned n_req;
        logic [31:0] tgt;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        n_total = 0; n_bad = 0; cyc = 0;
        m_valid = 1'b0; m_flushing = 1'b0; m_pc = RST_PC;
        p_ready = 100; p_dec = 100; p_rsp = 100;

        // Streaming from reset with an always-ready 1-cycle memory.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        check_eq("boot_req0", obs_req_addr, RST_PC);
        check_eq("boot_dec0_valid", 32'(obs_dec_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("boot_req1", obs_req_addr, RST_PC + 32'd4);
        check_eq("boot_dec1_valid", 32'(obs_dec_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("boot_dec2_valid", 32'(obs_dec_valid), 32'd1);
        check_eq("boot_dec2_pc", obs_dec_pc, RST_PC);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);

        // Decode stalled: credits cap requests at the buffer depth.
        do_reset();
        p_dec = 0;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_acc) n_req++;
        end
        check_eq("stall_req_count", n_req, DEPTH);
        check_eq("stall_head_pc", obs_dec_pc, RST_PC);
        check_eq("stall_head_op", obs_dec_op, op_of(RST_PC));
        p_dec = 100;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect with two requests in flight.
        do_reset();
        p_rsp = 0;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0100);
        p_rsp = 100;
        first_addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (obs_acc && first_addr == 32'hDEAD_BEEF) first_addr = obs_req_addr;
        end
        check_eq("flush_next_req", first_addr, 32'h0000_0100);

        // Misaligned redirect coincident with a response.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b0, 32'h0);
        check_eq("align_req", obs_req_addr, 32'h0000_0200);
        check_eq("align_dropped", 32'(obs_dec_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect to the last word: the PC wraps to zero.
        do_reset();
        step(1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check_eq("wrap_req0", obs_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        check_eq("wrap_req1", obs_req_addr, 32'h0000_0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Reset with one buffered entry and one request in flight.
        do_reset();
        p_dec = 0;
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        p_rsp = 0;
        do_reset();
        p_dec = 100; p_rsp = 100;
        step(1'b1, 1'b0, 32'h0);
        check_eq("rst_mid_dec0", 32'(obs_dec_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("rst_mid_dec1", 32'(obs_dec_valid), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("rst_mid_dec2", 32'(obs_dec_valid), 32'd1);
        check_eq("rst_mid_pc", obs_dec_pc, RST_PC);

        // Random traffic with redirects and occasional resets.
        for (int w = 0; w < 15; w++) begin
            p_ready = $urandom_range(100, 20);
            p_dec   = $urandom_range(100, 20);
            p_rsp   = $urandom_range(100, 20);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(499) == 0) begin
                    do_reset();
                end else begin
                    tgt = $urandom;
                    if (tgt[0]) tgt = 32'hFFFF_FFE0 | {27'd0, tgt[6:2]};
                    step(1'b1, ($urandom_range(99) < 3), tgt);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
